avalon_stream_switcher: RTL and testbench

AVALON_STREAM_SWITCHER -- requirements
Module: avalon_stream_switcher

---
 rtl/avalon_stream_switcher.sv | 158 +++++++++++++++
 tb/tb_avalon_stream_switcher.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_stream_switcher.sv
// avalon_stream_switcher
// Routes one of NUM_CH Avalon-ST style sinks onto a single registered source.
// A channel change blanks the source (all zeros) for BLANK_CYCLES cycles so
// downstream logic never sees samples straddling the switch.
// Optional feature macro: AVALON_SWITCHER_ERR_STICKY_EN adds err_clear and
// err_sticky, a sticky OR of every error seen on a valid output cycle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_PASS  | active_sel channel registered onto source_* every cycle
// S_BLANK | source_* forced to zero while r_cnt counts down to 0

module avalon_stream_switcher #(
  parameter int NUM_CH       = 4,
  parameter int SEL_W        = 2,
  parameter int DATA_W       = 12,
  parameter int ERR_W        = 2,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
`ifdef AVALON_SWITCHER_ERR_STICKY_EN
  input  logic                       err_clear,
  output logic [ERR_W-1:0]           err_sticky,
`endif
  input  logic [SEL_W-1:0]           select,
  input  logic [NUM_CH*DATA_W-1:0]   sink_data,
  input  logic [NUM_CH-1:0]          sink_valid,
  input  logic [NUM_CH*ERR_W-1:0]    sink_error,
  output logic [DATA_W-1:0]          source_data,
  output logic                       source_valid,
  output logic [ERR_W-1:0]           source_error,
  output logic [SEL_W-1:0]           active_sel,
  output logic                       switching
);

  typedef enum logic {S_PASS = 1'b0, S_BLANK = 1'b1} state_t;

  localparam logic [SEL_W:0] LP_NUM_CH   = (SEL_W+1)'(NUM_CH);
  localparam logic [7:0]     LP_BLANK_LD = 8'(BLANK_CYCLES - 1);
  localparam bit             LP_BLANK_EN = (BLANK_CYCLES > 0);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SEL_W-1:0]    r_active_sel;
  logic [SEL_W-1:0]    w_sel_nxt;
  logic [7:0]          r_cnt;
  logic [7:0]          w_cnt_nxt;
  logic [DATA_W-1:0]   r_src_data;
  logic [DATA_W-1:0]   w_data_nxt;
  logic                r_src_valid;
  logic                w_valid_nxt;
  logic [ERR_W-1:0]    r_src_error;
  logic [ERR_W-1:0]    w_error_nxt;

  logic                w_accept;
  logic [SEL_W-1:0]    w_route_sel;
  logic [DATA_W-1:0]   w_ch_data;
  logic                w_ch_valid;
  logic [ERR_W-1:0]    w_ch_error;

  // A request is only honoured when it names a real channel that differs
  // from the one currently routed or pending.
  assign w_accept = ({1'b0, select} < LP_NUM_CH) && (select != r_active_sel);

  // With no blanking the new channel must be routed on the accepting edge,
  // so the mux looks ahead at select instead of the registered channel.
  assign w_route_sel = (w_accept && !LP_BLANK_EN) ? select : r_active_sel;

  // Channel mux: pick the routed channel's data, valid and error.
  always_comb begin
    w_ch_data  = '0;
    w_ch_valid = 1'b0;
    w_ch_error = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_route_sel == SEL_W'(k)) begin
        w_ch_data  = sink_data[k*DATA_W +: DATA_W];
        w_ch_valid = sink_valid[k];
        w_ch_error = sink_error[k*ERR_W +: ERR_W];
      end
    end
  end

  // Next-state and next-output decode; a fresh accepted change always wins,
  // which also restarts blanking when it arrives mid-BLANK.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_active_sel;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = w_ch_data;
    w_valid_nxt = w_ch_valid;
    w_error_nxt = w_ch_error;
    if (w_accept) begin
      w_sel_nxt = select;
      if (LP_BLANK_EN) begin
        w_state_nxt = S_BLANK;
        w_cnt_nxt   = LP_BLANK_LD;
        w_data_nxt  = '0;
        w_valid_nxt = 1'b0;
        w_error_nxt = '0;
      end
    end else if (r_state == S_BLANK) begin
      if (r_cnt == 8'd0) begin
        w_state_nxt = S_PASS;
      end else begin
        w_cnt_nxt   = r_cnt - 8'd1;
        w_data_nxt  = '0;
        w_valid_nxt = 1'b0;
        w_error_nxt = '0;
      end
    end
  end

  // State, channel, counter and source registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_PASS;
      r_active_sel <= '0;
      r_cnt        <= 8'd0;
      r_src_data   <= '0;
      r_src_valid  <= 1'b0;
      r_src_error  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_active_sel <= w_sel_nxt;
      r_cnt        <= w_cnt_nxt;
      r_src_data   <= w_data_nxt;
      r_src_valid  <= w_valid_nxt;
      r_src_error  <= w_error_nxt;
    end
  end

  assign source_data  = r_src_data;
  assign source_valid = r_src_valid;
  assign source_error = r_src_error;
  assign active_sel   = r_active_sel;
  assign switching    = (r_state == S_BLANK);

`ifdef AVALON_SWITCHER_ERR_STICKY_EN
  logic [ERR_W-1:0] r_err_sticky;

  // Sticky error: a coincident new error survives err_clear, and channel
  // switches leave the accumulated value alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_sticky <= '0;
    end else begin
      r_err_sticky <= (err_clear ? '0 : r_err_sticky) |
                      (r_src_valid ? r_src_error : '0);
    end
  end

  assign err_sticky = r_err_sticky;
`else
  // Sticky error tracking not built.
`endif

endmodule

// File: tb/tb_avalon_stream_switcher.sv
// Directed bench for avalon_stream_switcher: default build (4 ch, 8 blank
// cycles), a 3-channel instance for out-of-range selects and a zero-blank
// instance. Sticky error checks are compiled when the feature macro is set.

module tb_avalon_stream_switcher;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   select;
  logic [47:0]  sink_data;
  logic [3:0]   sink_valid;
  logic [7:0]   sink_error;

  logic [11:0]  a_data, c_data, z_data;
  logic         a_valid, c_valid, z_valid;
  logic [1:0]   a_error, c_error, z_error;
  logic [1:0]   a_sel, c_sel, z_sel;
  logic         a_sw, c_sw, z_sw;

  logic [35:0]  sink_data3;
  logic [2:0]   sink_valid3;
  logic [5:0]   sink_error3;

  int n_total = 0;
  int n_pass  = 0;

  assign sink_data3  = sink_data[35:0];
  assign sink_valid3 = sink_valid[2:0];
  assign sink_error3 = sink_error[5:0];

`ifdef AVALON_SWITCHER_ERR_STICKY_EN
  logic       err_clear;
  logic [1:0] a_sticky, c_sticky, z_sticky;
`endif

  always #5 clk = ~clk;

  avalon_stream_switcher u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
`ifdef AVALON_SWITCHER_ERR_STICKY_EN
    .err_clear    (err_clear),
    .err_sticky   (a_sticky),
`endif
    .select       (select),
    .sink_data    (sink_data),
    .sink_valid   (sink_valid),
    .sink_error   (sink_error),
    .source_data  (a_data),
    .source_valid (a_valid),
    .source_error (a_error),
    .active_sel   (a_sel),
    .switching    (a_sw)
  );

  avalon_stream_switcher #(.NUM_CH(3)) u_dut3 (
    .clk          (clk),
    .reset_n      (reset_n),
`ifdef AVALON_SWITCHER_ERR_STICKY_EN
    .err_clear    (err_clear),
    .err_sticky   (c_sticky),
`endif
    .select       (select),
    .sink_data    (sink_data3),
    .sink_valid   (sink_valid3),
    .sink_error   (sink_error3),
    .source_data  (c_data),
    .source_valid (c_valid),
    .source_error (c_error),
    .active_sel   (c_sel),
    .switching    (c_sw)
  );

  avalon_stream_switcher #(.BLANK_CYCLES(0)) u_dut0 (
    .clk          (clk),
    .reset_n      (reset_n),
`ifdef AVALON_SWITCHER_ERR_STICKY_EN
    .err_clear    (err_clear),
    .err_sticky   (z_sticky),
`endif
    .select       (select),
    .sink_data    (sink_data),
    .sink_valid   (sink_valid),
    .sink_error   (sink_error),
    .source_data  (z_data),
    .source_valid (z_valid),
    .source_error (z_error),
    .active_sel   (z_sel),
    .switching    (z_sw)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_channels();
    sink_data  = {12'hD33, 12'hC22, 12'hB11, 12'h5A5};
    sink_valid = 4'b1111;
    sink_error = 8'h00;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    select  = 2'd0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    select     = 2'($urandom_range(0, 3));
    sink_data  = {$urandom(), 16'($urandom())};
    sink_valid = 4'($urandom());
    sink_error = 8'($urandom());
    tick();
    tick();
    n_total++;
    if ({a_data, a_valid, a_error, a_sel, a_sw} !== 18'd0)
      $display("FAIL reset_outputs got data=%h v=%b e=%b sel=%0d sw=%b want all 0",
               a_data, a_valid, a_error, a_sel, a_sw);
    else n_pass++;
    select     = 2'd0;
    sink_data[11:0] = 12'h5A5;
    sink_valid[0]   = 1'b1;
    sink_error[1:0] = 2'b00;
    reset_n = 1'b1;
    tick();
    n_total++;
    if (a_data !== 12'h5A5 || a_valid !== 1'b1)
      $display("FAIL reset_release got data=%h v=%b want 5a5 1", a_data, a_valid);
    else n_pass++;
  endtask

  task automatic test_blank_switch();
    do_reset();
    set_channels();
    tick();
    select = 2'd2;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_total++;
      if (a_valid !== 1'b0 || a_sw !== 1'b1 || a_data !== 12'h000)
        $display("FAIL blank_cycle_%0d got v=%b sw=%b data=%h want 0 1 000",
                 i, a_valid, a_sw, a_data);
      else n_pass++;
    end
    tick();
    n_total++;
    if (a_data !== 12'hC22 || a_valid !== 1'b1 || a_sw !== 1'b0 || a_sel !== 2'd2)
      $display("FAIL blank_end got data=%h v=%b sw=%b sel=%0d want c22 1 0 2",
               a_data, a_valid, a_sw, a_sel);
    else n_pass++;
    // latency 1 on the new channel
    sink_data[35:24] = 12'h777;
    tick();
    n_total++;
    if (a_data !== 12'h777)
      $display("FAIL pass_follow got data=%h want 777", a_data);
    else n_pass++;
    // data follows even when channel valid drops
    sink_valid[2] = 1'b0;
    sink_data[35:24] = 12'h123;
    tick();
    n_total++;
    if (a_data !== 12'h123 || a_valid !== 1'b0)
      $display("FAIL data_no_valid got data=%h v=%b want 123 0", a_data, a_valid);
    else n_pass++;
  endtask

  task automatic test_restart();
    do_reset();
    set_channels();
    tick();
    select = 2'd1;
    tick();
    tick();
    tick();
    select = 2'd3;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_total++;
      if (a_sw !== 1'b1 || a_valid !== 1'b0 || a_sel !== 2'd3)
        $display("FAIL restart_blank_%0d got sw=%b v=%b sel=%0d want 1 0 3",
                 i, a_sw, a_valid, a_sel);
      else n_pass++;
    end
    tick();
    n_total++;
    if (a_data !== 12'hD33 || a_valid !== 1'b1 || a_sw !== 1'b0)
      $display("FAIL restart_end got data=%h v=%b sw=%b want d33 1 0",
               a_data, a_valid, a_sw);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    do_reset();
    set_channels();
    select = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (c_sw !== 1'b0 || c_sel !== 2'd0 || c_data !== 12'h5A5 || c_valid !== 1'b1)
        $display("FAIL oor_select_%0d got sw=%b sel=%0d data=%h v=%b want 0 0 5a5 1",
                 i, c_sw, c_sel, c_data, c_valid);
      else n_pass++;
    end
  endtask

  task automatic test_zero_blank();
    do_reset();
    set_channels();
    select = 2'd1;
    tick();
    n_total++;
    if (z_data !== 12'hB11 || z_sw !== 1'b0 || z_sel !== 2'd1)
      $display("FAIL b0_switch1 got data=%h sw=%b sel=%0d want b11 0 1", z_data, z_sw, z_sel);
    else n_pass++;
    select = 2'd2;
    tick();
    n_total++;
    if (z_data !== 12'hC22 || z_valid !== 1'b1 || z_sw !== 1'b0 || z_sel !== 2'd2)
      $display("FAIL b0_switch2 got data=%h v=%b sw=%b sel=%0d want c22 1 0 2",
               z_data, z_valid, z_sw, z_sel);
    else n_pass++;
  endtask

  task automatic test_reset_mid_blank();
    do_reset();
    set_channels();
    tick();
    select = 2'd2;
    tick();
    tick();
    tick();
    tick();
    n_total++;
    if (a_sw !== 1'b1)
      $display("FAIL midblank_pre got sw=%b want 1", a_sw);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({a_data, a_valid, a_error, a_sel, a_sw} !== 18'd0)
      $display("FAIL midblank_reset got data=%h v=%b e=%b sel=%0d sw=%b want all 0",
               a_data, a_valid, a_error, a_sel, a_sw);
    else n_pass++;
    select = 2'd0;
    tick();
    reset_n = 1'b1;
    tick();
    n_total++;
    if (a_data !== 12'h5A5 || a_valid !== 1'b1 || a_sw !== 1'b0)
      $display("FAIL midblank_release got data=%h v=%b sw=%b want 5a5 1 0",
               a_data, a_valid, a_sw);
    else n_pass++;
  endtask

`ifdef AVALON_SWITCHER_ERR_STICKY_EN
  task automatic test_sticky();
    err_clear = 1'b0;
    do_reset();
    set_channels();
    tick();
    sink_error[1:0] = 2'b10;
    tick();
    sink_error[1:0] = 2'b00;
    tick();
    tick();
    tick();
    n_total++;
    if (a_sticky !== 2'b10)
      $display("FAIL sticky_hold got %b want 10", a_sticky);
    else n_pass++;
    sink_error[1:0] = 2'b01;
    tick();
    sink_error[1:0] = 2'b00;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    n_total++;
    if (a_sticky !== 2'b01)
      $display("FAIL sticky_clear_coincide got %b want 01", a_sticky);
    else n_pass++;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    n_total++;
    if (a_sticky !== 2'b00)
      $display("FAIL sticky_clear got %b want 00", a_sticky);
    else n_pass++;
  endtask
`endif

  initial begin
`ifdef AVALON_SWITCHER_ERR_STICKY_EN
    err_clear = 1'b0;
`endif
    reset_n    = 1'b0;
    select     = 2'd0;
    sink_data  = '0;
    sink_valid = '0;
    sink_error = '0;
    test_reset();
    test_blank_switch();
    test_restart();
    test_out_of_range();
    test_zero_blank();
    test_reset_mid_blank();
`ifdef AVALON_SWITCHER_ERR_STICKY_EN
    test_sticky();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
